sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Parametrised N-channel arbiter in front of one synchronous SRAM port.
- Each upstream channel uses the en/we/addr/data_w/data_r master signalling, extended with a stall and a read-valid return.
- Round-robin grant each cycle; read data is routed back to the issuing channel after a fixed SRAM read latency.
- Lets IF and MEM stages, plus any later masters, share a single SRAM macro.

Parameters:
- N_CH, 2, number of upstream master channels (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- RD_LAT, 1, SRAM read latency in cycles, from the en cycle to data_r valid (1..4).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- m_en  in  N_CH  per-channel request.
- m_we  in  N_CH*DATA_W/8  per-channel byte write enables; all-zero means a read.
- m_addr  in  N_CH*ADDR_W  per-channel address.
- m_data_w  in  N_CH*DATA_W  per-channel write data.
- m_stall  out  N_CH  request not accepted this cycle; master holds its request.
- m_rvalid  out  N_CH  one-cycle pulse: m_data_r slice valid for that channel.
- m_data_r  out  N_CH*DATA_W  per-channel read data, held until that channel's next return.
- s_en  out  1  SRAM enable.
- s_we  out  DATA_W/8  SRAM byte enables.
- s_addr  out  ADDR_W  SRAM address.
- s_data_w  out  DATA_W  SRAM write data.
- s_data_r  in  DATA_W  SRAM read data.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - round-robin pointer = 0.
  - tag pipeline cleared.
  - m_rvalid = 0, m_data_r = 0.
  - Combinational outputs follow m_en (= 0 in practice).
- Arbitration (combinational, same cycle):
  - Among set m_en bits, grant the first channel at or after ptr, wrapping modulo N_CH.
  - At most one grant per cycle.
  - m_stall[i] = m_en[i] & ~grant[i].
  - m_stall[i] = 0 when m_en[i] = 0.
- Slave drive:
  - With a grant: s_en = 1; s_we/s_addr/s_data_w are the granted channel's slices.
  - Without a grant: s_en = 0, s_we = 0, s_addr = 0, s_data_w = 0.
- Pointer update (registered): on any grant, ptr <= granted_id + 1 (wraps to 0 after N_CH-1). No grant leaves ptr unchanged.
- Tag pipeline:
  - RD_LAT-deep shift register of {valid, id}.
  - Stage 0 is loaded with valid = grant & (granted m_we == 0) and id = granted channel.
  - Writes never produce a return.
- Return:
  - When the last stage's valid is high in a cycle, s_data_r is presented on that cycle's edge.
  - On that edge, m_data_r slice[id] <= s_data_r and m_rvalid[id] <= 1.
  - m_rvalid is therefore registered: it is high in the cycle after data arrives at the SRAM pins. End-to-end read latency is RD_LAT + 1 cycles from grant.
- Back-to-back: one read per cycle sustained. The pipeline never stalls and no return is dropped.
- Simultaneous return and new request on the same channel is legal; both proceed.
- Single channel (N_CH = 1): grant = m_en, m_stall is always 0.
- Reset mid-operation: in-flight tags discarded; no m_rvalid pulses after reset releases.
- Masters must hold en/we/addr/data_w stable while stalled. The arbiter does not latch requests.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- When defined:
  - Adds output perf_stall  N_CH*32: per-channel count of cycles with m_stall[i] = 1.
  - Counters saturate at 32'hFFFF_FFFF and clear on reset.
  - Adds input perf_clr (1 bit): synchronous clear of all counters, taking priority over increment.
- When undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- Single read: N_CH=2, RD_LAT=1; ch0 m_en=1, m_we=0, addr=0x100, SRAM returns 0xDEADBEEF -> s_en=1 and s_addr=0x100 same cycle; m_rvalid[0]=1 and m_data_r[0]=0xDEADBEEF two cycles after grant; m_stall=00.
- Contention: ch0 and ch1 request continuously for 4 cycles from reset -> grants 0,1,0,1; m_stall alternates 10,01,10,01 (bit1..bit0).
- Write then read: ch1 writes 0x12345678 with we=4'b0011 at 0x40 -> s_we=0011, no m_rvalid; next cycle ch1 reads 0x40 -> single rvalid on ch1 only.
- Latency sweep: RD_LAT=3, 3 back-to-back reads ch0,ch1,ch0 with SRAM data A,B,C -> rvalid order ch0(A), ch1(B), ch0(C) on consecutive cycles starting 4 cycles after the first grant.
- Reset mid-flight: RD_LAT=3; issue a read, assert resetn=0 one cycle later for 2 cycles -> no m_rvalid ever; ptr=0, so the next contention grants ch0 first.
- SRAM_ARB_PERF_EN: ch1 stalled 5 cycles by contention -> perf_stall[ch1]=5; pulse perf_clr -> 0 next cycle.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Bus bundle between N upstream masters, the arbiter and one synchronous SRAM port.
// The master side also plays the SRAM (drives s_data_r), which is how a bench or wrapper models the macro.
interface sram_arbiter_if #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int WB = DATA_W / 8;

    logic [N_CH-1:0]        m_en;
    logic [N_CH*WB-1:0]     m_we;
    logic [N_CH*ADDR_W-1:0] m_addr;
    logic [N_CH*DATA_W-1:0] m_data_w;
    logic [N_CH-1:0]        m_stall;
    logic [N_CH-1:0]        m_rvalid;
    logic [N_CH*DATA_W-1:0] m_data_r;
    logic                   s_en;
    logic [WB-1:0]          s_we;
    logic [ADDR_W-1:0]      s_addr;
    logic [DATA_W-1:0]      s_data_w;
    logic [DATA_W-1:0]      s_data_r;

    modport master (
        output m_en, m_we, m_addr, m_data_w, s_data_r,
        input  m_stall, m_rvalid, m_data_r, s_en, s_we, s_addr, s_data_w
    );

    modport slave (
        input  m_en, m_we, m_addr, m_data_w, s_data_r,
        output m_stall, m_rvalid, m_data_r, s_en, s_we, s_addr, s_data_w
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin N-channel arbiter in front of one synchronous SRAM port with tagged read return.
// Optional SRAM_ARB_PERF_EN adds per-channel saturating stall counters (perf_stall, perf_clr).
module sram_arbiter #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               resetn,
    sram_arbiter_if.slave      bus
`ifdef SRAM_ARB_PERF_EN
    ,
    input  logic               perf_clr,
    output logic [N_CH*32-1:0] perf_stall
`endif
);
    localparam int WB   = DATA_W / 8;
    localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [ID_W-1:0]              ptr_r;
    logic                         gnt_vld_s;
    logic [ID_W-1:0]              gnt_id_s;
    logic [N_CH-1:0]              grant_s;
    logic [N_CH-1:0]              stall_s;
    logic                         rd_s;
    logic [RD_LAT-1:0]            tag_vld_r;
    logic [RD_LAT-1:0][ID_W-1:0]  tag_id_r;
    logic [N_CH-1:0]              rvalid_r;
    logic [N_CH*DATA_W-1:0]       data_r_r;

    // Pick the first requesting channel at or after ptr, wrapping modulo N_CH.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_vld_s = 1'b0;
        gnt_id_s  = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(ptr_r) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end else begin
                idx = idx;
            end
            if (!gnt_vld_s && bus.m_en[idx]) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = idx[ID_W-1:0];
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
    end

    // One-hot grant vector and stall for every requester that lost.
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant_s[i] = gnt_vld_s && (gnt_id_s == ID_W'(i));
        end
        stall_s = bus.m_en & ~grant_s;
    end

    assign bus.m_stall = stall_s;

    // Mux the granted channel onto the SRAM pins; idle pins are driven to zero.
    always_comb begin
        if (gnt_vld_s) begin
            bus.s_en     = 1'b1;
            bus.s_we     = bus.m_we[int'(gnt_id_s)*WB +: WB];
            bus.s_addr   = bus.m_addr[int'(gnt_id_s)*ADDR_W +: ADDR_W];
            bus.s_data_w = bus.m_data_w[int'(gnt_id_s)*DATA_W +: DATA_W];
        end else begin
            bus.s_en     = 1'b0;
            bus.s_we     = '0;
            bus.s_addr   = '0;
            bus.s_data_w = '0;
        end
        rd_s = gnt_vld_s && (bus.s_we == '0);
    end

    // Round-robin pointer moves just past the winner; idle cycles keep it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_r <= '0;
        end else if (gnt_vld_s) begin
            if (gnt_id_s == ID_W'(N_CH - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= gnt_id_s + ID_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Read tags travel alongside the SRAM latency so returns need no address compare.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_vld_r <= '0;
            tag_id_r  <= '0;
        end else begin
            tag_vld_r[0] <= rd_s;
            tag_id_r[0]  <= gnt_id_s;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_id_r[i]  <= tag_id_r[i-1];
            end
        end
    end

    // Capture SRAM data into the owning channel's slice and pulse its rvalid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid_r <= '0;
            data_r_r <= '0;
        end else begin
            rvalid_r <= '0;
            if (tag_vld_r[RD_LAT-1]) begin
                rvalid_r[tag_id_r[RD_LAT-1]]                            <= 1'b1;
                data_r_r[int'(tag_id_r[RD_LAT-1])*DATA_W +: DATA_W] <= bus.s_data_r;
            end else begin
                data_r_r <= data_r_r;
            end
        end
    end

    assign bus.m_rvalid = rvalid_r;
    assign bus.m_data_r = data_r_r;

`ifdef SRAM_ARB_PERF_EN
    logic [N_CH-1:0][31:0] perf_cnt_r;

    // Saturating per-channel stall counters; perf_clr wins over increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_cnt_r <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (perf_clr) begin
                    perf_cnt_r[i] <= 32'h0000_0000;
                end else if (stall_s[i] && (perf_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    perf_cnt_r[i] <= perf_cnt_r[i] + 32'h0000_0001;
                end else begin
                    perf_cnt_r[i] <= perf_cnt_r[i];
                end
            end
        end
    end

    assign perf_stall = perf_cnt_r;
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_sram_arbiter;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    sram_arbiter_if #(.N_CH(2), .ADDR_W(32), .DATA_W(32)) b1 ();
    sram_arbiter_if #(.N_CH(2), .ADDR_W(32), .DATA_W(32)) b3 ();

`ifdef SRAM_ARB_PERF_EN
    logic        perf_clr1, perf_clr3;
    logic [63:0] perf_stall1, perf_stall3;
    sram_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(b1), .perf_clr(perf_clr1), .perf_stall(perf_stall1));
    sram_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .resetn(resetn), .bus(b3), .perf_clr(perf_clr3), .perf_stall(perf_stall3));
`else
    sram_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(b1));
    sram_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .resetn(resetn), .bus(b3));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        b1.m_en = 2'b00; b1.m_we = 8'h00; b1.m_addr = 64'h0; b1.m_data_w = 64'h0; b1.s_data_r = 32'h0;
        b3.m_en = 2'b00; b3.m_we = 8'h00; b3.m_addr = 64'h0; b3.m_data_w = 64'h0; b3.s_data_r = 32'h0;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        idle();
        next_cycle();
        next_cycle();
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        idle();
`ifdef SRAM_ARB_PERF_EN
        perf_clr1 = 1'b0;
        perf_clr3 = 1'b0;
`endif
        next_cycle();
        next_cycle();
        checks++; if (b1.m_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid1 got %b exp 00", b1.m_rvalid); end
        checks++; if (b1.m_data_r !== 64'h0) begin errors++; $display("FAIL reset_data_r1 got %h exp 0", b1.m_data_r); end
        checks++; if (b3.m_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid3 got %b exp 00", b3.m_rvalid); end
        checks++; if (b1.m_stall !== 2'b00) begin errors++; $display("FAIL reset_stall got %b exp 00", b1.m_stall); end
        checks++; if (b1.s_en !== 1'b0 || b1.s_addr !== 32'h0) begin errors++; $display("FAIL reset_slave got en=%b addr=%h exp 0/0", b1.s_en, b1.s_addr); end
    endtask

    task automatic test_single_read;
        do_reset();
        b1.m_en = 2'b01; b1.m_addr = {32'h0, 32'h0000_0100};
        #1;
        checks++; if (b1.s_en !== 1'b1) begin errors++; $display("FAIL single_s_en got %b exp 1", b1.s_en); end
        checks++; if (b1.s_addr !== 32'h0000_0100) begin errors++; $display("FAIL single_s_addr got %h exp 00000100", b1.s_addr); end
        checks++; if (b1.m_stall !== 2'b00) begin errors++; $display("FAIL single_stall got %b exp 00", b1.m_stall); end
        next_cycle();
        idle();
        b1.s_data_r = 32'hDEAD_BEEF;
        #1;
        checks++; if (b1.m_rvalid !== 2'b00) begin errors++; $display("FAIL single_early_rvalid got %b exp 00", b1.m_rvalid); end
        next_cycle();
        b1.s_data_r = 32'h0;
        checks++; if (b1.m_rvalid !== 2'b01) begin errors++; $display("FAIL single_rvalid got %b exp 01", b1.m_rvalid); end
        checks++; if (b1.m_data_r[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", b1.m_data_r[31:0]); end
        next_cycle();
        checks++; if (b1.m_rvalid !== 2'b00) begin errors++; $display("FAIL single_pulse_end got %b exp 00", b1.m_rvalid); end
        checks++; if (b1.m_data_r[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data_hold got %h exp deadbeef", b1.m_data_r[31:0]); end
    endtask

    task automatic test_contention;
        logic [1:0]  exp_stall;
        logic [31:0] exp_addr;
        do_reset();
        b1.m_en = 2'b11; b1.m_addr = {32'h0000_0020, 32'h0000_0010};
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_stall = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_addr  = (k % 2 == 0) ? 32'h0000_0010 : 32'h0000_0020;
            checks++; if (b1.m_stall !== exp_stall) begin errors++; $display("FAIL contention_stall[%0d] got %b exp %b", k, b1.m_stall, exp_stall); end
            checks++; if (b1.s_addr !== exp_addr) begin errors++; $display("FAIL contention_addr[%0d] got %h exp %h", k, b1.s_addr, exp_addr); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_write_then_read;
        do_reset();
        b1.m_en = 2'b10; b1.m_we = 8'b0011_0000;
        b1.m_addr = {32'h0000_0040, 32'h0}; b1.m_data_w = {32'h1234_5678, 32'h0};
        #1;
        checks++; if (b1.s_en !== 1'b1 || b1.s_we !== 4'b0011) begin errors++; $display("FAIL wr_s_we got en=%b we=%b exp 1/0011", b1.s_en, b1.s_we); end
        checks++; if (b1.s_addr !== 32'h0000_0040) begin errors++; $display("FAIL wr_s_addr got %h exp 00000040", b1.s_addr); end
        checks++; if (b1.s_data_w !== 32'h1234_5678) begin errors++; $display("FAIL wr_s_data_w got %h exp 12345678", b1.s_data_w); end
        next_cycle();
        b1.m_we = 8'h00;
        #1;
        checks++; if (b1.s_en !== 1'b1 || b1.s_we !== 4'b0000) begin errors++; $display("FAIL rd_s_we got en=%b we=%b exp 1/0000", b1.s_en, b1.s_we); end
        next_cycle();
        idle();
        b1.s_data_r = 32'hCAFE_F00D;
        #1;
        checks++; if (b1.m_rvalid !== 2'b00) begin errors++; $display("FAIL wr_no_return got %b exp 00", b1.m_rvalid); end
        next_cycle();
        b1.s_data_r = 32'h0;
        checks++; if (b1.m_rvalid !== 2'b10) begin errors++; $display("FAIL rd_rvalid got %b exp 10", b1.m_rvalid); end
        checks++; if (b1.m_data_r[63:32] !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_data got %h exp cafef00d", b1.m_data_r[63:32]); end
        next_cycle();
        checks++; if (b1.m_rvalid !== 2'b00) begin errors++; $display("FAIL rd_single_pulse got %b exp 00", b1.m_rvalid); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        b3.m_en = 2'b01; b3.m_addr = {32'h0, 32'h0000_00A0};
        next_cycle();
        b3.m_en = 2'b10; b3.m_addr = {32'h0000_00B0, 32'h0};
        #1;
        checks++; if (b3.s_en !== 1'b1 || b3.s_addr !== 32'h0000_00B0) begin errors++; $display("FAIL b2b_grant_ch1 got en=%b addr=%h exp 1/000000b0", b3.s_en, b3.s_addr); end
        next_cycle();
        b3.m_en = 2'b01; b3.m_addr = {32'h0, 32'h0000_00C0};
        next_cycle();
        idle();
        b3.s_data_r = 32'hAAAA_0001;
        #1;
        checks++; if (b3.m_rvalid !== 2'b00) begin errors++; $display("FAIL b2b_early got %b exp 00", b3.m_rvalid); end
        next_cycle();
        b3.s_data_r = 32'hBBBB_0002;
        checks++; if (b3.m_rvalid !== 2'b01 || b3.m_data_r[31:0] !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_ret_a got rv=%b d=%h exp 01/aaaa0001", b3.m_rvalid, b3.m_data_r[31:0]); end
        next_cycle();
        b3.s_data_r = 32'hCCCC_0003;
        checks++; if (b3.m_rvalid !== 2'b10 || b3.m_data_r[63:32] !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_ret_b got rv=%b d=%h exp 10/bbbb0002", b3.m_rvalid, b3.m_data_r[63:32]); end
        next_cycle();
        b3.s_data_r = 32'h0;
        checks++; if (b3.m_rvalid !== 2'b01 || b3.m_data_r[31:0] !== 32'hCCCC_0003) begin errors++; $display("FAIL b2b_ret_c got rv=%b d=%h exp 01/cccc0003", b3.m_rvalid, b3.m_data_r[31:0]); end
        checks++; if (b3.m_data_r[63:32] !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_hold_b got %h exp bbbb0002", b3.m_data_r[63:32]); end
        next_cycle();
        checks++; if (b3.m_rvalid !== 2'b00) begin errors++; $display("FAIL b2b_done got %b exp 00", b3.m_rvalid); end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        b3.m_en = 2'b01; b3.m_addr = {32'h0, 32'h0000_0300};
        next_cycle();
        idle();
        resetn = 1'b0;
        #1;
        checks++; if (b3.m_rvalid !== 2'b00) begin errors++; $display("FAIL midrst_in_reset got %b exp 00", b3.m_rvalid); end
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        b3.s_data_r = 32'h5555_5555;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (b3.m_rvalid !== 2'b00) begin errors++; $display("FAIL midrst_no_rvalid[%0d] got %b exp 00", k, b3.m_rvalid); end
            next_cycle();
        end
        b3.s_data_r = 32'h0;
        b3.m_en = 2'b11; b3.m_addr = {32'h0000_0222, 32'h0000_0111};
        #1;
        checks++; if (b3.m_stall !== 2'b10 || b3.s_addr !== 32'h0000_0111) begin errors++; $display("FAIL midrst_ptr got stall=%b addr=%h exp 10/00000111", b3.m_stall, b3.s_addr); end
        next_cycle();
        idle();
    endtask

`ifdef SRAM_ARB_PERF_EN
    task automatic test_perf;
        do_reset();
        perf_clr1 = 1'b0;
        b1.m_en = 2'b11; b1.m_addr = {32'h0000_0020, 32'h0000_0010};
        for (int k = 0; k < 10; k++) begin
            next_cycle();
        end
        idle();
        #1;
        checks++; if (perf_stall1[63:32] !== 32'd5) begin errors++; $display("FAIL perf_ch1 got %0d exp 5", perf_stall1[63:32]); end
        checks++; if (perf_stall1[31:0] !== 32'd5) begin errors++; $display("FAIL perf_ch0 got %0d exp 5", perf_stall1[31:0]); end
        perf_clr1 = 1'b1;
        next_cycle();
        perf_clr1 = 1'b0;
        checks++; if (perf_stall1 !== 64'h0) begin errors++; $display("FAIL perf_clr got %h exp 0", perf_stall1); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_read();
        test_contention();
        test_write_then_read();
        test_back_to_back();
        test_reset_midflight();
`ifdef SRAM_ARB_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
